// File: rtl/tag_nios_system_leds_out.sv
// tag_nios_system_leds_out
// Avalon-MM LED output port: DATA register with atomic OUTSET/OUTCLEAR
// access, plus an optional hardware blink engine (BLINK_MASK, BLINK_PERIOD,
// STATUS). The blink engine is built only when LEDS_OUT_BLINK_EN is defined;
// otherwise addresses 2, 3 and 6 read 0, ignore writes, and out_port = data.
module tag_nios_system_leds_out #(
    parameter int unsigned           WIDTH       = 10,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           PERIOD_W    = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [WIDTH-1:0]         out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA         = 3'd0,
        ADDR_RSVD1        = 3'd1,
        ADDR_BLINK_MASK   = 3'd2,
        ADDR_BLINK_PERIOD = 3'd3,
        ADDR_OUTSET       = 3'd4,
        ADDR_OUTCLEAR     = 3'd5,
        ADDR_STATUS       = 3'd6,
        ADDR_RSVD7        = 3'd7
    } addr_e;

    logic              wr;
    logic [WIDTH-1:0]  data;
    logic [WIDTH-1:0]  wdata;
    logic [31:0]       rd_mux;

    // Bits of the bus word above the implemented register widths are don't-care.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    // DATA register: plain write, atomic set and atomic clear.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data <= wdata;
                ADDR_OUTSET:   data <= data | wdata;
                ADDR_OUTCLEAR: data <= data & ~wdata;
                default:       data <= data;
            endcase
        end
    end

`ifdef LEDS_OUT_BLINK_EN
    logic [WIDTH-1:0]    blink_mask;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;
    logic [PERIOD_W-1:0] wperiod;

    assign wperiod = writedata[PERIOD_W-1:0];

    // Blink mask register; applied to out_port from the next cycle on.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask <= '0;
        end else if (wr && address == ADDR_BLINK_MASK) begin
            blink_mask <= wdata;
        end
    end

    // Blink engine: a period write restarts the countdown with phase cleared;
    // otherwise phase toggles each time the down-counter wraps through zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (wr && address == ADDR_BLINK_PERIOD) begin
            period <= wperiod;
            cnt    <= (wperiod == '0) ? '0 : wperiod - PERIOD_W'(1);
            phase  <= 1'b0;
        end else if (period == '0) begin
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (cnt == '0) begin
            cnt    <= period - PERIOD_W'(1);
            phase  <= ~phase;
        end else begin
            cnt    <= cnt - PERIOD_W'(1);
        end
    end

    // LED drive comes only from registers: masked LEDs go dark in phase 1.
    assign out_port = data & ~(blink_mask & {WIDTH{phase}});

    // Read mux, blink build.
    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:         rd_mux = 32'(data);
            ADDR_BLINK_MASK:   rd_mux = 32'(blink_mask);
            ADDR_BLINK_PERIOD: rd_mux = 32'(period);
            ADDR_STATUS:       rd_mux = {31'd0, phase};
            default:           rd_mux = '0;
        endcase
    end
`else
    // Without the blink engine the LEDs follow DATA directly.
    assign out_port = data;

    // Read mux, plain build: only DATA is readable.
    always_comb begin
        rd_mux = '0;
        if (address == ADDR_DATA) begin
            rd_mux = 32'(data);
        end
    end
`endif

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
